// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the iterative encryption engine.
// Contents: state type (16 bytes, index i = FIPS byte i), block size,
// RCON table, GF(2^8) helpers, S-box, SubBytes and ShiftRows functions.
// Byte layout: column c = bytes 4c..4c+3, row r = byte 4c+r.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [AES_BLOCK_BYTES-1:0][7:0] aes_state_t;

  // Entry 0 is unused; rounds index entries 1..10.
  localparam logic [10:0][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                       8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    logic [7:0] r;
    if (idx <= 4'd10) r = RCON[idx];
    else r = 8'h00;
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = b[i] ? (p ^ aa) : p;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed arithmetically: multiplicative inverse as x^254
  // (product of x^2, x^4, ..., x^128; maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic aes_state_t sub_bytes(input aes_state_t s);
    aes_state_t o;
    for (int i = 0; i < AES_BLOCK_BYTES; i++) o[i] = sbox(s[i]);
    return o;
  endfunction

  // Row r rotates left by r columns.
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c+r] = s[4*((c+r)%4)+r];
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational AES-128 key schedule step: one round key to the next.
// Ports: rk (current round key), rcon (round constant byte) -> rk_n (next round key).
module aes_key_step
  import aes_pkg::*;
(
  input  aes_state_t rk,
  input  logic [7:0] rcon,
  output aes_state_t rk_n
);

  logic [3:0][7:0] t_s;

  // RotWord + SubWord of the last word, rcon folded into its first byte,
  // then each new word chains off the previous new word.
  always_comb begin
    t_s[0] = sbox(rk[13]) ^ rcon;
    t_s[1] = sbox(rk[14]);
    t_s[2] = sbox(rk[15]);
    t_s[3] = sbox(rk[12]);
    for (int i = 0; i < 4; i++) begin
      rk_n[i]      = rk[i] ^ t_s[i];
      rk_n[4+i]    = rk[4+i] ^ rk_n[i];
      rk_n[8+i]    = rk[8+i] ^ rk_n[4+i];
      rk_n[12+i]   = rk[12+i] ^ rk_n[8+i];
    end
  end

endmodule

// File: rtl/aes_mix_columns.sv
// Combinational AES MixColumns over all four columns.
// Ports: in_state (16-byte state) -> out_state (mixed state).
module aes_mix_columns
  import aes_pkg::*;
(
  input  aes_state_t in_state,
  output aes_state_t out_state
);

  // Per-column multiply by the fixed {02,03,01,01} circulant matrix.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      out_state[4*c]   = xtime(in_state[4*c]) ^ (xtime(in_state[4*c+1]) ^ in_state[4*c+1]) ^
                         in_state[4*c+2] ^ in_state[4*c+3];
      out_state[4*c+1] = in_state[4*c] ^ xtime(in_state[4*c+1]) ^
                         (xtime(in_state[4*c+2]) ^ in_state[4*c+2]) ^ in_state[4*c+3];
      out_state[4*c+2] = in_state[4*c] ^ in_state[4*c+1] ^ xtime(in_state[4*c+2]) ^
                         (xtime(in_state[4*c+3]) ^ in_state[4*c+3]);
      out_state[4*c+3] = (xtime(in_state[4*c]) ^ in_state[4*c]) ^ in_state[4*c+1] ^
                         in_state[4*c+2] ^ xtime(in_state[4*c+3]);
    end
  end

endmodule

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock, round keys
// generated on the fly, one block in flight, valid/ready on both sides.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_key (input
// stream, 16 bytes each); out_valid/out_ready/out_data (ciphertext stream);
// busy (RUN or DONE); round (debug round counter, 0 in IDLE).
module aes_enc_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data [AES_BLOCK_BYTES],
  input  logic [7:0] in_key  [AES_BLOCK_BYTES],
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data [AES_BLOCK_BYTES],
  output logic       busy,
  output logic [3:0] round
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  localparam logic [3:0] NR_L = 4'(NR);

  state_e     state_r;
  aes_state_t st_r;
  aes_state_t rk_r;
  logic [3:0] round_r;

  aes_state_t in_st_s;
  aes_state_t in_key_s;
  aes_state_t sr_s;
  aes_state_t mc_s;
  aes_state_t rk_n_s;
  aes_state_t next_st_s;
  logic       last_s;

  // Port byte arrays to/from the packed internal state.
  always_comb begin
    for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
      in_st_s[i]  = in_data[i];
      in_key_s[i] = in_key[i];
      out_data[i] = st_r[i];
    end
  end

  assign sr_s   = shift_rows(sub_bytes(st_r));
  assign last_s = (round_r == NR_L);

  aes_mix_columns u_mix (
    .in_state  (sr_s),
    .out_state (mc_s)
  );

  aes_key_step u_key (
    .rk   (rk_r),
    .rcon (rcon_of(round_r)),
    .rk_n (rk_n_s)
  );

  // The final round bypasses MixColumns.
  always_comb begin
    if (last_s) next_st_s = sr_s ^ rk_n_s;
    else next_st_s = mc_s ^ rk_n_s;
  end

  assign round = round_r;

  // Controller FSM with state, key, round and handshake output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      st_r      <= {AES_BLOCK_BYTES{8'h00}};
      rk_r      <= {AES_BLOCK_BYTES{8'h00}};
      round_r   <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            st_r     <= in_st_s ^ in_key_s;
            rk_r     <= in_key_s;
            round_r  <= 4'd1;
            state_r  <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          st_r <= next_st_s;
          rk_r <= rk_n_s;
          // Counter parks at NR so it never exceeds it while DONE.
          if (last_s) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
          end else begin
            round_r <= round_r + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            round_r   <= 4'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          round_r   <= 4'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Self-checking bench for aes_enc_round_ctrl against a FIPS-197 style
// software AES-128 model (full key expansion, byte-array rounds).
module tb_aes_enc_round_ctrl;

  localparam int NR = 10;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data [16];
  logic [7:0] in_key  [16];
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data [16];
  logic       busy;
  logic [3:0] round;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] sbox_tab [256];

  aes_enc_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .round(round)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int prod = 0;
    int aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) prod = prod ^ aa;
      aa = aa << 1;
      if (aa > 255) aa = aa ^ 'h11b;
    end
    return 8'(prod);
  endfunction

  // S-box by brute-force inverse search plus the bitwise affine definition.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = b;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]],
               sbox_tab[tmp[7:0]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= NR; r++) begin
      for (int b = 0; b < 16; b++) s[b] = sbox_tab[s[b]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < NR) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_block(input logic [127:0] key, input logic [127:0] pt);
    for (int i = 0; i < 16; i++) begin
      in_data[i] = pt[127-8*i -: 8];
      in_key[i]  = key[127-8*i -: 8];
    end
  endtask

  function automatic logic [127:0] get_out();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = out_data[i];
    return v;
  endfunction

  // Steps until out_valid or the budget runs out; returns edges waited.
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive_block(128'h0, 128'h0);
    step(); step();
    rst = 1'b0;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (round !== 4'd0) begin tests_failed++; $display("FAIL reset_round got %0d want 0", round); end
    tests_run++; if (get_out() !== 128'h0) begin tests_failed++; $display("FAIL reset_out_data got %h want 0", get_out()); end
  endtask

  task automatic test_fips_c1();
    int lat;
    out_ready = 1'b1;
    drive_block(K1, P1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    drive_block(K2, P2);  // inputs may change freely after the accept edge
    tests_run++; if (busy !== 1'b1 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL c1_accept busy=%b in_ready=%b want 1/0", busy, in_ready); end
    wait_out(lat);
    tests_run++; if (lat != NR) begin tests_failed++; $display("FAIL c1_latency got %0d want %0d", lat, NR); end
    tests_run++; if (get_out() !== C1) begin tests_failed++; $display("FAIL c1_data got %h want %h", get_out(), C1); end
    step();
    tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL c1_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_fips_b_rounds();
    int bad = 0;
    out_ready = 1'b1;
    drive_block(K2, P2);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int e = 1; e <= NR; e++) begin
      if (round !== 4'(e) || out_valid !== 1'b0) bad++;
      step();
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL b_round_seq got %0d bad cycles want 0", bad); end
    tests_run++; if (out_valid !== 1'b1 || round !== 4'(NR)) begin tests_failed++; $display("FAIL b_done out_valid=%b round=%0d want 1/%0d", out_valid, round, NR); end
    tests_run++; if (get_out() !== C2) begin tests_failed++; $display("FAIL b_data got %h want %h", get_out(), C2); end
    step();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    out_ready = 1'b0;
    drive_block(K1, P1);
    in_valid = 1'b1;
    step();
    drive_block(K2, P2);  // second vector offered throughout DONE
    wait_out(lat);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_timeout waited %0d edges", lat); end
    for (int k = 0; k < 5; k++) begin
      step();
      if (get_out() !== C1 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || round !== 4'd0) begin tests_failed++; $display("FAIL bp_release in_ready=%b out_valid=%b round=%0d", in_ready, out_valid, round); end
    step();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_no_capture busy=%b want 0", busy); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    out_ready = 1'b1;
    drive_block(K1, P1);
    in_valid = 1'b1;
    step();
    drive_block(K2, P2);  // in_valid stays high during RUN
    wait_out(lat);
    tests_run++; if (get_out() !== C1 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL busy_first got %h want %h", get_out(), C1); end
    step();  // DONE -> IDLE
    step();  // vector 2 accepted
    in_valid = 1'b0;
    tests_run++; if (busy !== 1'b1 || round !== 4'd1) begin tests_failed++; $display("FAIL busy_second_accept busy=%b round=%0d want 1/1", busy, round); end
    wait_out(lat);
    tests_run++; if (get_out() !== C2 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL busy_second got %h want %h", get_out(), C2); end
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    int n = 0;
    int seen = 0;
    out_ready = 1'b1;
    drive_block(K1, P1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    while (round !== 4'd5 && n < 20) begin step(); n++; end
    tests_run++; if (round !== 4'd5) begin tests_failed++; $display("FAIL mid_reach_round5 got %0d want 5", round); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++; if (out_valid !== 1'b0 || round !== 4'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset out_valid=%b round=%0d in_ready=%b busy=%b", out_valid, round, in_ready, busy); end
    for (int k = 0; k < 12; k++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL mid_no_output got %0d valid cycles want 0", seen); end
    drive_block(K1, P1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    tests_run++; if (get_out() !== C1 || lat != NR) begin tests_failed++; $display("FAIL mid_fresh got %h lat %0d want %h lat %0d", get_out(), lat, C1, NR); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [127:0] keys [20];
    logic [127:0] pts  [20];
    logic [127:0] expq [$];
    logic [127:0] want;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int extra = 0;
    for (int i = 0; i < 20; i++) begin
      keys[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      pts[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    drive_block(keys[0], pts[0]);
    in_valid = 1'b1;
    while (got < 20 && cyc < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        tests_run++;
        if (expq.size() == 0) begin
          tests_failed++; $display("FAIL b2b_unexpected got %h with no block pending", get_out());
        end else begin
          want = expq.pop_front();
          if (get_out() !== want) begin tests_failed++; $display("FAIL b2b_block%0d got %h want %h", got, get_out(), want); end
        end
        got++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        expq.push_back(aes_model(keys[sent], pts[sent]));
        sent++;
      end
      step();
      cyc++;
      if (sent < 20) drive_block(keys[sent], pts[sent]);
      else drive_block({$urandom(), $urandom(), $urandom(), $urandom()}, 128'h0);
      in_valid = (sent < 20) ? 1'b1 : 1'b0;
    end
    tests_run++; if (got != 20 || sent != 20 || expq.size() != 0) begin tests_failed++; $display("FAIL b2b_count got %0d sent %0d pending %0d want 20/20/0", got, sent, expq.size()); end
    out_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      if (out_valid === 1'b1) extra++;
    end
    tests_run++; if (extra != 0) begin tests_failed++; $display("FAIL b2b_duplicate got %0d extra valid cycles want 0", extra); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_c1();
    test_fips_b_rounds();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
